// File: rtl/thermostat_zone_ctrl_if.sv
// Button, sensor and status bundle of the multi-zone thermostat.
// The master side drives buttons and sensors; the slave side is the controller.
interface thermostat_zone_ctrl_if #(
  parameter int TEMP_W = 8,
  parameter int ZONES  = 4,
  parameter int SEL_W  = (ZONES > 1) ? $clog2(ZONES) : 1
);
  logic                      Set;
  logic                      Up;
  logic                      Down;
  logic [SEL_W-1:0]          ZoneSel;
  logic [ZONES*TEMP_W-1:0]   SensorTemp;
  logic                      SensorValid;
  logic                      EditMode;
  logic [TEMP_W-1:0]         SelSetTemp;
  logic [ZONES*TEMP_W-1:0]   SetTemps;
  logic [ZONES-1:0]          Heat;
  logic [ZONES-1:0]          Cool;

  modport master (
    output Set, Up, Down, ZoneSel, SensorTemp, SensorValid,
    input  EditMode, SelSetTemp, SetTemps, Heat, Cool
  );

  modport slave (
    input  Set, Up, Down, ZoneSel, SensorTemp, SensorValid,
    output EditMode, SelSetTemp, SetTemps, Heat, Cool
  );
endinterface

// File: rtl/thermostat_zone_ctrl.sv
// Multi-zone thermostat: per-zone setpoints edited by Set/Up/Down buttons and
// a per-zone heat/cool FSM with hysteresis and a minimum-run lockout.
module thermostat_zone_ctrl #(
  parameter int TEMP_W      = 8,
  parameter int ZONES       = 4,
  parameter int HYST        = 2,
  parameter int MIN_RUN     = 1000,
  parameter int T_MIN       = 50,
  parameter int T_MAX       = 90,
  parameter int DEFAULT_SET = 70
) (
  input  logic                  clk,
  input  logic                  Reset,
  thermostat_zone_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(MIN_RUN + 1);

  localparam logic [TEMP_W-1:0] SET_MIN = TEMP_W'(T_MIN);
  localparam logic [TEMP_W-1:0] SET_MAX = TEMP_W'(T_MAX);
  localparam logic [TEMP_W-1:0] SET_DEF = TEMP_W'(DEFAULT_SET);
  localparam logic [TEMP_W:0]   BAND    = (TEMP_W+1)'(HYST);
  localparam logic [CNT_W-1:0]  RUN_MAX = CNT_W'(MIN_RUN);

  typedef enum logic [1:0] {IDLE, HEAT, COOL} zone_state_t;

  logic                set_q, up_q, down_q, edit_q;
  logic                set_e, up_e, down_e;
  logic [TEMP_W-1:0]   setpt_q [ZONES];
  zone_state_t         state_q [ZONES];
  zone_state_t         state_d [ZONES];
  logic [CNT_W-1:0]    cnt_q   [ZONES];
  logic [ZONES-1:0]    heat_q, cool_q;

  assign set_e  = bus.Set  & ~set_q;
  assign up_e   = bus.Up   & ~up_q;
  assign down_e = bus.Down & ~down_q;

  // Up/Down use edit_q as it was before any Set toggle on the same edge.
  always_ff @(posedge clk) begin
    if (Reset) begin
      set_q  <= 1'b0;
      up_q   <= 1'b0;
      down_q <= 1'b0;
      edit_q <= 1'b0;
      for (int unsigned z = 0; z < ZONES; z++) setpt_q[z] <= SET_DEF;
    end else begin
      set_q  <= bus.Set;
      up_q   <= bus.Up;
      down_q <= bus.Down;
      if (set_e) edit_q <= ~edit_q;
      for (int unsigned z = 0; z < ZONES; z++) begin
        if (edit_q && (int'(bus.ZoneSel) == int'(z)) && (up_e ^ down_e)) begin
          if (up_e && (setpt_q[z] < SET_MAX))
            setpt_q[z] <= setpt_q[z] + TEMP_W'(1);
          else if (down_e && (setpt_q[z] > SET_MIN))
            setpt_q[z] <= setpt_q[z] - TEMP_W'(1);
        end
      end
    end
  end

  always_comb begin
    bus.SelSetTemp = '0;
    for (int unsigned z = 0; z < ZONES; z++) begin
      if (int'(bus.ZoneSel) == int'(z)) bus.SelSetTemp = setpt_q[z];
    end
  end

  always_comb begin
    bus.SetTemps = '0;
    for (int unsigned z = 0; z < ZONES; z++) bus.SetTemps[z*TEMP_W +: TEMP_W] = setpt_q[z];
  end

  assign bus.EditMode = edit_q;
  assign bus.Heat     = heat_q;
  assign bus.Cool     = cool_q;

  // Band edges are one bit wider so hi cannot wrap and lo clamps at zero.
  always_comb begin
    logic [TEMP_W:0] temp, setx, lo, hi;
    for (int unsigned z = 0; z < ZONES; z++) begin
      state_d[z] = state_q[z];
      temp = {1'b0, bus.SensorTemp[z*TEMP_W +: TEMP_W]};
      setx = {1'b0, setpt_q[z]};
      lo   = (setx < BAND) ? '0 : setx - BAND;
      hi   = setx + BAND;
      if (bus.SensorValid) begin
        unique case (state_q[z])
          IDLE: begin
            if (temp < lo)      state_d[z] = HEAT;
            else if (temp > hi) state_d[z] = COOL;
          end
          HEAT: if ((temp >= setx) && (cnt_q[z] >= RUN_MAX)) state_d[z] = IDLE;
          COOL: if ((temp <= setx) && (cnt_q[z] >= RUN_MAX)) state_d[z] = IDLE;
          default: state_d[z] = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      heat_q <= '0;
      cool_q <= '0;
      for (int unsigned z = 0; z < ZONES; z++) begin
        state_q[z] <= IDLE;
        cnt_q[z]   <= '0;
      end
    end else begin
      for (int unsigned z = 0; z < ZONES; z++) begin
        state_q[z] <= state_d[z];
        heat_q[z]  <= (state_d[z] == HEAT);
        cool_q[z]  <= (state_d[z] == COOL);
        if ((state_d[z] != state_q[z]) && (state_d[z] != IDLE))
          cnt_q[z] <= '0;
        else if ((state_q[z] != IDLE) && (cnt_q[z] < RUN_MAX))
          cnt_q[z] <= cnt_q[z] + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_thermostat_zone_ctrl.sv
// Directed bench for thermostat_zone_ctrl; stimulus queues expectations and
// a negedge monitor drains and checks them.
module tb_thermostat_zone_ctrl;

  typedef enum int {K_EDIT, K_SEL, K_SETS, K_HEAT, K_COOL} chk_kind_t;
  typedef struct {
    string       name;
    chk_kind_t   kind;
    int          zone;
    logic [31:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sbq[$];

  thermostat_zone_ctrl_if #(.TEMP_W(8), .ZONES(4)) bus ();

  thermostat_zone_ctrl #(.MIN_RUN(4)) dut (
    .clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_val(input string name, input chk_kind_t kind, input int zone, input logic [31:0] v);
    exp_t e;
    e.name = name; e.kind = kind; e.zone = zone; e.exp = v;
    sbq.push_back(e);
  endtask

  task automatic press(input int b);
    case (b)
      0: bus.Set = 1'b1;
      1: bus.Up = 1'b1;
      default: bus.Down = 1'b1;
    endcase
    tick();
    bus.Set = 1'b0; bus.Up = 1'b0; bus.Down = 1'b0;
    tick();
  endtask

  task automatic set_temp(input int z, input int t);
    bus.SensorTemp[z*8 +: 8] = 8'(t);
  endtask

  initial begin
    exp_t e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        case (e.kind)
          K_EDIT:  act = 32'(bus.EditMode);
          K_SEL:   act = 32'(bus.SelSetTemp);
          K_SETS:  act = bus.SetTemps;
          K_HEAT:  act = 32'(bus.Heat[e.zone]);
          default: act = 32'(bus.Cool[e.zone]);
        endcase
        n_checks++;
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", e.name, act, act, e.exp, e.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    bus.Set = 1'b0; bus.Up = 1'b0; bus.Down = 1'b0;
    bus.ZoneSel = '0;
    bus.SensorValid = 1'b1;
    for (int z = 0; z < 4; z++) set_temp(z, 70);

    // Reset
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    expect_val("reset_sets", K_SETS, 0, {8'd70, 8'd70, 8'd70, 8'd70});
    expect_val("reset_edit", K_EDIT, 0, 0);
    for (int z = 0; z < 4; z++) begin
      expect_val("reset_heat", K_HEAT, z, 0);
      expect_val("reset_cool", K_COOL, z, 0);
    end
    tick();
    for (int z = 0; z < 4; z++) begin
      bus.ZoneSel = 2'(z);
      expect_val("reset_sel", K_SEL, z, 70);
      tick();
    end

    // Edit mode and saturation on zone 2
    press(0);
    expect_val("edit_on", K_EDIT, 0, 1);
    bus.ZoneSel = 2'd2;
    for (int i = 0; i < 25; i++) press(1);
    expect_val("sat_max_sets", K_SETS, 0, {8'd70, 8'd90, 8'd70, 8'd70});
    expect_val("sat_max_sel", K_SEL, 2, 90);
    tick();
    press(2);
    press(2);
    expect_val("down_twice", K_SEL, 2, 88);
    tick();
    bus.Up = 1'b1;
    tick(50);
    bus.Up = 1'b0;
    tick();
    expect_val("up_held_once", K_SEL, 2, 89);
    tick();
    press(0);
    expect_val("edit_off", K_EDIT, 0, 0);
    press(1);
    expect_val("up_ignored", K_SEL, 2, 89);
    tick();

    // Simultaneous edges
    press(0);
    bus.Up = 1'b1; bus.Down = 1'b1;
    tick();
    bus.Up = 1'b0; bus.Down = 1'b0;
    tick();
    expect_val("up_down_same", K_SEL, 2, 89);
    tick();
    bus.Set = 1'b1; bus.Up = 1'b1;
    tick();
    bus.Set = 1'b0; bus.Up = 1'b0;
    tick();
    expect_val("set_up_incr", K_SEL, 2, 90);
    expect_val("set_up_edit", K_EDIT, 0, 0);
    tick();

    // Hysteresis heat on zone 0
    bus.ZoneSel = 2'd0;
    set_temp(0, 68);
    tick();
    expect_val("heat_68_idle", K_HEAT, 0, 0);
    tick();
    set_temp(0, 67);
    tick();
    expect_val("heat_67_on", K_HEAT, 0, 1);
    set_temp(0, 70);
    tick();
    expect_val("heat_lock_1", K_HEAT, 0, 1);
    tick(2);
    expect_val("heat_lock_3", K_HEAT, 0, 1);
    tick(2);
    expect_val("heat_released", K_HEAT, 0, 0);
    tick();

    // Cooling and no direct swap on zone 1
    set_temp(1, 73);
    tick();
    expect_val("cool_on", K_COOL, 1, 1);
    expect_val("cool_no_heat", K_HEAT, 1, 0);
    tick(5);
    expect_val("cool_held", K_COOL, 1, 1);
    set_temp(1, 40);
    tick();
    expect_val("swap_cool_off", K_COOL, 1, 0);
    expect_val("swap_idle_heat", K_HEAT, 1, 0);
    tick();
    expect_val("swap_heat_on", K_HEAT, 1, 1);
    expect_val("swap_cool_off2", K_COOL, 1, 0);
    set_temp(1, 70);
    tick(5);
    expect_val("heat1_released", K_HEAT, 1, 0);
    bus.SensorValid = 1'b0;
    set_temp(1, 40);
    tick(3);
    expect_val("invalid_no_heat", K_HEAT, 1, 0);
    expect_val("invalid_no_cool", K_COOL, 1, 0);
    set_temp(1, 70);
    bus.SensorValid = 1'b1;
    tick();

    // Reset mid-run on zone 3
    set_temp(3, 60);
    tick();
    expect_val("z3_heat_on", K_HEAT, 3, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_val("rst_mid_heat", K_HEAT, 3, 0);
    expect_val("rst_mid_sets", K_SETS, 0, {8'd70, 8'd70, 8'd70, 8'd70});
    expect_val("rst_mid_edit", K_EDIT, 0, 0);
    set_temp(3, 70);
    tick(3);

    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/thermostat_zone_ctrl.md
Name: thermostat_zone_ctrl

Overview:
Parametrised multi-zone successor to the single-zone thermostat. It holds one setpoint per zone and adjusts the selected zone's setpoint with the Set/Up/Down buttons. Each zone runs a heat/cool FSM with hysteresis and a minimum-run lockout. Setpoints feed sseg_display; Heat/Cool drive the HVAC relays.

Parameters:
TEMP_W, 8, width of every temperature value (unsigned, degrees)
ZONES, 4, number of independent zones (1..16)
HYST, 2, hysteresis band in degrees either side of setpoint
MIN_RUN, 1000, minimum clk cycles Heat/Cool stays asserted once turned on (>=1)
T_MIN, 50, lowest legal setpoint
T_MAX, 90, highest legal setpoint
DEFAULT_SET, 70, setpoint loaded on reset (T_MIN <= DEFAULT_SET <= T_MAX)

Ports:
clk  input  1  system clock
Reset  input  1  synchronous, active-high reset
Set  input  1  button, level; each rising edge toggles edit mode
Up  input  1  button, level; rising edge increments the selected setpoint
Down  input  1  button, level; rising edge decrements the selected setpoint
ZoneSel  input  max(1,clog2(ZONES))  zone addressed by Up/Down and SelSetTemp
SensorTemp  input  ZONES*TEMP_W  current temperature; zone i at bits [i*TEMP_W +: TEMP_W]
SensorValid  input  1  SensorTemp is valid this cycle
EditMode  output  1  1 = Up/Down are active
SelSetTemp  output  TEMP_W  setpoint of zone ZoneSel (combinational read of register)
SetTemps  output  ZONES*TEMP_W  all setpoints, same packing as SensorTemp
Heat  output  ZONES  per-zone heat request
Cool  output  ZONES  per-zone cool request

Behaviour:
- Reset, checked before all else: every setpoint = DEFAULT_SET; EditMode = 0; button history regs = 0; all zone FSMs = IDLE; run counters = 0; Heat = Cool = 0.
- Edge detect: each button has a prev register. An edge is button=1 and prev=0 on a clock edge. A held button produces exactly one edge.
- Set edge toggles EditMode on that clock edge.
- Up edge with EditMode=1: setpoint[ZoneSel] += 1, saturating at T_MAX. The new value is visible the cycle after the edge is sampled.
- Down edge with EditMode=1: setpoint[ZoneSel] -= 1, saturating at T_MIN.
- Up and Down edges on the same cycle: no change.
- Set edge and Up/Down edge on the same cycle: the Up/Down action uses the EditMode value from before the toggle.
- EditMode=0: Up/Down edges are ignored (history registers still update).
- ZoneSel >= ZONES: Up/Down ignored; SelSetTemp = 0.
- Arithmetic: lo = set - HYST and hi = set + HYST are computed in TEMP_W+1 bits. lo clamps at 0; hi never overflows.
- Per-zone FSM, states IDLE / HEAT / COOL. It evaluates only on cycles with SensorValid=1; otherwise state is held and the run counter still counts.
  - IDLE -> HEAT when temp < lo.
  - IDLE -> COOL when temp > hi.
  - HEAT -> IDLE when temp >= set AND run counter >= MIN_RUN.
  - COOL -> IDLE when temp <= set AND run counter >= MIN_RUN.
  - HEAT <-> COOL directly is forbidden; the zone must pass through IDLE (at least one cycle).
- Run counter: cleared on entry to HEAT/COOL; increments each cycle in HEAT/COOL; saturates at MIN_RUN. Width is clog2(MIN_RUN+1).
- Outputs are registered: Heat[i] = (state==HEAT), Cool[i] = (state==COOL). Outputs follow the state with zero added latency: the output changes on the same edge the state register changes, one cycle after the qualifying SensorTemp is sampled.
- A setpoint change mid-run takes effect on the next valid sample. The lockout still applies.
- Heat[i] and Cool[i] are never both 1.
- Reset mid-run forces IDLE immediately, regardless of the lockout.

Test Plan:
- Reset: assert Reset 2 cycles -> SetTemps all 70, EditMode=0, Heat=Cool=0; SelSetTemp=70 for ZoneSel=0..3.
- Edit/saturation: Set pulse, ZoneSel=2, 25 Up pulses -> zone 2 = 90 (saturates), other zones stay 70. Up held 50 cycles -> exactly one increment. Up with EditMode=0 -> no change.
- Simultaneous: Up and Down rising on the same cycle -> no change. Set edge plus Up edge with EditMode=1 -> increment applied and EditMode becomes 0.
- Hysteresis heat: zone 0 set=70, MIN_RUN=4. Temp 68 -> stays IDLE. Temp 67 -> Heat[0]=1 next cycle. Temp 70 one cycle later -> Heat held until 4 cycles elapsed, then 0.
- Cool and no direct swap: zone 1 in COOL, sensor jumps to 40 after lockout -> Cool[1]=0 for at least one cycle (IDLE) before Heat[1]=1. SensorValid=0 while temp is out of band -> no transition.
- Reset mid-run: Heat[3]=1 with counter < MIN_RUN, pulse Reset -> Heat[3]=0 next cycle and setpoints back to 70.
